uart_seq_trig: RTL
==================

Name: uart_seq_trig

Overview:
- Parametrised UART receive trigger, successor to the single-byte UART trigger.
- Receives frames with configurable data width and optional parity. Checks stop and parity bits.
- Fires a one-cycle trigger when the last seq_len correctly received characters match a programmable masked sequence.
- Sits in the trigger unit beside the other protocol triggers. The RX pin is asynchronous to clk.

Parameters:
DATA_W, 8, data bits per frame (5..9), sent LSB first
SEQ_LEN, 4, maximum characters in the match sequence (>=1)
CNT_W, 16, width of baud_cnt

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
RX  in  1  serial input; asynchronous; idles high
baud_cnt  in  CNT_W  clocks per bit; minimum legal value 4
par_en  in  1  1 = frame carries a parity bit after the data
par_odd  in  1  1 = odd parity, 0 = even parity
seq_len  in  $clog2(SEQ_LEN+1)  active sequence length; 0 is treated as 1, values >SEQ_LEN are clamped to SEQ_LEN
match  in  SEQ_LEN*DATA_W  slot k occupies bits [k*DATA_W +: DATA_W]; slot 0 is the first character of the sequence
mask  in  SEQ_LEN*DATA_W  same layout as match; mask bit 1 = don't care
rx_data  out  DATA_W  last received character
rx_rdy  out  1  one-cycle pulse: a good frame was received
frm_err  out  1  one-cycle pulse: stop bit sampled low
par_err  out  1  one-cycle pulse: parity mismatch
UARTtrig  out  1  one-cycle pulse: sequence matched

Behaviour:
- Reset (asynchronous, active-low rst_n, clock clk):
  - All outputs go to 0. rx_data goes to 0.
  - Synchroniser flops reset to 1 (idle).
  - FSM goes to IDLE. History count goes to 0.
  - A reset mid-frame abandons the frame; no pulse is produced.
- RX synchronisation:
  - RX passes through a 2-flop synchroniser; rxs is the synchronised value.
  - All sampling uses rxs.
- Frame configuration:
  - baud_cnt, par_en and par_odd are latched when a start is detected. They are held constant for that frame.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - A falling edge of rxs (previous 1, current 0) loads the bit counter to 0 and the baud counter to 0, then enters START.
  - rxs stuck low after a completed frame does not retrigger; only a new falling edge starts a frame.
- START:
  - Samples rxs when the baud counter reaches (baud_cnt>>1)-1.
  - rxs=1: false start, back to IDLE, no pulse.
  - rxs=0: clear the baud counter and enter DATA.
- DATA:
  - Samples every baud_cnt clocks, at counter == baud_cnt-1, then the counter clears.
  - Each sample is shifted in MSB-first into a DATA_W shift register, so the first bit received ends at bit 0.
  - After DATA_W samples: go to PAR if par_en, else STOP.
- PAR:
  - One sample, same timing as DATA.
  - Error if (XOR of data bits ^ sampled bit ^ par_odd) != 0. Even parity means the total count of ones, including the parity bit, is even.
- STOP:
  - One sample, same timing. Then return to IDLE on the next cycle.
  - Back-to-back frames (next start edge immediately after the stop sample) must be received.
- Frame result (registered, asserted on the cycle after the stop sample):
  - Stop=0: frm_err=1.
  - Else parity bad: par_err=1.
  - Else: rx_rdy=1 and rx_data updated.
  - frm_err takes priority; at most one of the three pulses fires per frame.
  - rx_data updates only on a good frame.
- History:
  - An SEQ_LEN-deep shift register hist[0..SEQ_LEN-1], where hist[0] is the newest character.
  - A valid count saturates at SEQ_LEN.
  - A good frame shifts in rx_data and increments the count.
  - frm_err or par_err clears the count to 0. History data is not cleared.
- Match:
  - Evaluated on each good frame, using the updated history. Let L = the effective seq_len.
  - Character k (0..L-1) matches when ((hist[L-1-k] ^ match slot k) & ~mask slot k) == 0.
  - UARTtrig=1 in the same cycle as rx_rdy if count >= L and all L characters match.
  - Overlapping matches fire on every qualifying frame. Example: L=2, sequence "AA", input "AAA" fires twice.
- Live inputs:
  - match, mask and seq_len are read live at evaluation time.
  - Changing them mid-stream does not clear history.
- Timing summary:
  - Latency from the RX start-bit falling edge to the pulse is 2 sync clocks + (baud_cnt>>1) + (DATA_W + par_en + 1)*baud_cnt + 1 clocks, within ±1 clock.

Test Plan:
- DATA_W=8, baud_cnt=16, par_en=0, seq_len=1, match slot0=0x5A, mask=0; send 0x5A -> rx_rdy, rx_data=0x5A, UARTtrig=1 same cycle. Send 0x5B -> rx_rdy only.
- seq_len=3, slots 0x12,0x34,0x56; send 0x12,0x34,0x56 back-to-back -> UARTtrig only on the third rx_rdy. Send 0x12,0x99,0x56 -> no trigger.
- par_en=1, par_odd=0; send 0xA5 with parity 0 -> rx_rdy. Send 0xA5 with parity 1 -> par_err=1, no rx_rdy, history count 0. Then 0x34,0x56 -> no trigger (sequence broken).
- Stop bit driven low on frame 0x5A -> frm_err=1, rx_rdy=0, rx_data unchanged. Glitch RX low for 4 clocks (< baud_cnt/2) -> no activity, FSM back in IDLE.
- Mask slot0=0x0F, match slot0=0xA0, seq_len=1; send 0xA7 and 0xAF -> both trigger. Send 0xB0 -> no trigger.
- Assert rst_n low mid-DATA of frame 0x5A -> all outputs 0, no pulse. The next complete 0x5A frame is received and triggers normally.

Source files
------------

// File: rtl/uart_seq_trig.sv
// -----------------------------------------------------------------------------
// uart_seq_trig
//   UART receive trigger. It receives asynchronous serial frames with DATA_W
//   data bits (LSB first), an optional parity bit and one stop bit. It pulses
//   UARTtrig when the most recent seq_len good characters, taken in arrival
//   order, equal a programmable masked character sequence.
//
// Parameters
//   DATA_W   data bits per frame (5..9)
//   SEQ_LEN  maximum number of characters in the match sequence (>=1)
//   CNT_W    width of baud_cnt
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   RX        serial input, asynchronous to clk, idles high
//   baud_cnt  clocks per bit (>=4); latched at each start edge
//   par_en    frame carries a parity bit; latched at each start edge
//   par_odd   1 = odd parity, 0 = even; latched at each start edge
//   seq_len   active sequence length (0 acts as 1, clamped to SEQ_LEN)
//   match     SEQ_LEN slots of DATA_W bits; slot 0 is the oldest character
//   mask      same layout as match; 1 = don't-care bit
//   rx_data   last good character
//   rx_rdy    1-cycle pulse, good frame received
//   frm_err   1-cycle pulse, stop bit sampled low
//   par_err   1-cycle pulse, parity mismatch
//   UARTtrig  1-cycle pulse, sequence matched (coincides with rx_rdy)
// -----------------------------------------------------------------------------
module uart_seq_trig #(
    parameter int DATA_W  = 8,
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 16,
    localparam int SL_W   = $clog2(SEQ_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      RX,
    input  logic [CNT_W-1:0]          baud_cnt,
    input  logic                      par_en,
    input  logic                      par_odd,
    input  logic [SL_W-1:0]           seq_len,
    input  logic [SEQ_LEN*DATA_W-1:0] match,
    input  logic [SEQ_LEN*DATA_W-1:0] mask,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      rx_rdy,
    output logic                      frm_err,
    output logic                      par_err,
    output logic                      UARTtrig
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [SL_W-1:0] SEQ_MAX = SL_W'(SEQ_LEN);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t state, state_n;

    // ---------------------------------------------------------------------
    // RX synchroniser. rxs_d is one more stage used only for edge detection.
    // ---------------------------------------------------------------------
    logic rx_s1, rxs, rxs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rxs   <= rx_s1;
            rxs_d <= rxs;
        end
    end

    logic fall;
    assign fall = rxs_d & ~rxs;

    // ---------------------------------------------------------------------
    // Per-frame configuration and bit timing
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0]  baud_l;
    logic              par_en_l, par_odd_l;
    logic [CNT_W-1:0]  bcnt;
    logic [BC_W-1:0]   bitcnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bad;

    logic half_tick, bit_tick, last_bit;
    assign half_tick = (bcnt == ((baud_l >> 1) - CNT_W'(1)));
    assign bit_tick  = (bcnt == (baud_l - CNT_W'(1)));
    assign last_bit  = (bitcnt == BC_W'(DATA_W - 1));

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (fall) state_n = START;
            // A start bit that is high again at mid-bit was only a glitch.
            START: if (half_tick) state_n = rxs ? IDLE : DATA;
            DATA:  if (bit_tick && last_bit) state_n = par_en_l ? PAR : STOP;
            PAR:   if (bit_tick) state_n = STOP;
            STOP:  if (bit_tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // History and match evaluation. hist[0] is the newest character.
    // hist_n / cnt_n are the values after shifting in the frame being
    // completed, so the match sees the character that is just arriving.
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] hist   [SEQ_LEN];
    logic [DATA_W-1:0] hist_n [SEQ_LEN];
    logic [SL_W-1:0]   cnt, cnt_n;
    int                eff_l;
    logic              hit;

    always_comb begin
        hist_n[0] = shreg;
        for (int i = 1; i < SEQ_LEN; i++) hist_n[i] = hist[i-1];
        cnt_n = (cnt == SEQ_MAX) ? cnt : cnt + SL_W'(1);

        eff_l = int'(seq_len);
        if (eff_l == 0)       eff_l = 1;
        if (eff_l > SEQ_LEN)  eff_l = SEQ_LEN;

        // Slot k is compared with the character received L-1-k frames ago,
        // so slot 0 lines up with the oldest character of the window.
        hit = (int'(cnt_n) >= eff_l);
        for (int k = 0; k < SEQ_LEN; k++) begin
            for (int j = 0; j < SEQ_LEN; j++) begin
                if (k < eff_l && j == eff_l - 1 - k) begin
                    if (((hist_n[j] ^ match[k*DATA_W +: DATA_W])
                         & ~mask[k*DATA_W +: DATA_W]) != '0)
                        hit = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Datapath, frame result and history update
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_l    <= '0;
            par_en_l  <= 1'b0;
            par_odd_l <= 1'b0;
            bcnt      <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            par_bad   <= 1'b0;
            cnt       <= '0;
            rx_data   <= '0;
            rx_rdy    <= 1'b0;
            frm_err   <= 1'b0;
            par_err   <= 1'b0;
            UARTtrig  <= 1'b0;
            for (int i = 0; i < SEQ_LEN; i++) hist[i] <= '0;
        end else begin
            rx_rdy   <= 1'b0;
            frm_err  <= 1'b0;
            par_err  <= 1'b0;
            UARTtrig <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        baud_l    <= baud_cnt;
                        par_en_l  <= par_en;
                        par_odd_l <= par_odd;
                        bcnt      <= '0;
                        bitcnt    <= '0;
                        par_bad   <= 1'b0;
                    end
                end

                START: bcnt <= half_tick ? '0 : bcnt + CNT_W'(1);

                DATA: begin
                    bcnt <= bit_tick ? '0 : bcnt + CNT_W'(1);
                    if (bit_tick) begin
                        // Shift in from the top so the first bit ends at bit 0.
                        shreg  <= {rxs, shreg[DATA_W-1:1]};
                        bitcnt <= bitcnt + BC_W'(1);
                    end
                end

                PAR: begin
                    bcnt <= bit_tick ? '0 : bcnt + CNT_W'(1);
                    if (bit_tick) par_bad <= ^shreg ^ rxs ^ par_odd_l;
                end

                STOP: begin
                    bcnt <= bit_tick ? '0 : bcnt + CNT_W'(1);
                    if (bit_tick) begin
                        if (!rxs) begin
                            frm_err <= 1'b1;
                            cnt     <= '0;
                        end else if (par_bad) begin
                            par_err <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            rx_rdy   <= 1'b1;
                            rx_data  <= shreg;
                            cnt      <= cnt_n;
                            UARTtrig <= hit;
                            for (int i = 0; i < SEQ_LEN; i++) hist[i] <= hist_n[i];
                        end
                    end
                end

                default: ;
            endcase
        end
    end

endmodule
